// File: rtl/rx_iq_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_iq_serializer_if
// Purpose  : Bundles the signals around the I/Q serializer. This covers the
//            per-channel ready levels, the packed samples and the channel
//            mask coming from the DDC side. It also covers the byte-FIFO
//            write port and status going to the downstream side.
// Modports : master - serializer view (consumes samples, drives byte FIFO)
//            slave  - environment view (drives samples, observes byte FIFO)
// Signals  : rdy[NCH], iq_in[NCH*48], sync_mask[NCH], fifo_full,
//            wrenable, data_out[9], fifo_clear, overrun[NCH]
// Revision : 1.0 - initial release
// ============================================================================
interface rx_iq_serializer_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0]    rdy;
  logic [NCH*48-1:0] iq_in;
  logic [NCH-1:0]    sync_mask;
  logic              fifo_full;
  logic              wrenable;
  logic [8:0]        data_out;
  logic              fifo_clear;
  logic [NCH-1:0]    overrun;

  modport master (
    input  rdy, iq_in, sync_mask, fifo_full,
    output wrenable, data_out, fifo_clear, overrun
  );

  modport slave (
    output rdy, iq_in, sync_mask, fifo_full,
    input  wrenable, data_out, fifo_clear, overrun
  );
endinterface
`default_nettype wire

// File: rtl/rx_iq_serializer.sv
`default_nettype none
// ============================================================================
// Module   : rx_iq_serializer
// Purpose  : Captures one I/Q sample pair per receiver channel on the rising
//            edge of that channel's ready level. Each frame is then
//            serialized into the byte FIFO. A frame is channel 0 followed by
//            every channel selected in the mask latched at frame start. Each
//            channel block is 2*SB bytes, I first then Q, both MSB first.
//            data_out[8] marks the first byte of a block.
// Ports    : clock, reset   - system clock, synchronous active-high reset
//            bus (master)   - rdy, iq_in, sync_mask, fifo_full in;
//                             wrenable, data_out, fifo_clear, overrun out
// Params   : NCH (1..8) channel count, SB (2 or 3) bytes per I or Q sample
// Revision : 1.0 - initial release
// ============================================================================
module rx_iq_serializer #(
  parameter int NCH = 4,
  parameter int SB  = 3
) (
  input  logic                clock,
  input  logic                reset,
  rx_iq_serializer_if.master  bus
);

  localparam int         CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [2:0] LAST = 3'(2 * SB - 1);

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_SEND   = 3'd2,
    S_WAITCH = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t          state;
  logic [47:0]     hold [NCH];
  logic [NCH-1:0]  avail;
  logic [NCH-1:0]  overrun;
  logic [NCH-1:0]  rdy_q;
  logic [NCH-1:0]  mask_q;      // mask latched at the last frame start / clear
  logic [CW-1:0]   ch;
  logic [2:0]      b;
  logic [8:0]      data_q;
  logic            pend;        // a byte is being presented to the FIFO
  logic            fifo_clear;
  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  eff_mask;
  logic            nxt_found;
  logic [CW-1:0]   nxt_ch;

  // Bit 0 never selects anything; with NCH=1 the mask collapses to zero.
  assign eff_mask = bus.sync_mask & ~NCH'(1);
  assign rise     = bus.rdy & ~rdy_q;

  // Gating with fifo_full makes a presented byte count only when the FIFO
  // can take it. The byte is then re-presented until fifo_full drops.
  assign bus.wrenable   = pend & ~bus.fifo_full;
  assign bus.data_out   = data_q;
  assign bus.fifo_clear = fifo_clear;
  assign bus.overrun    = overrun;

  // Byte idx of a channel block: idx < SB selects I, else Q; MSB first.
  // With SB=2 the low byte of each 24-bit sample is simply never reached.
  function automatic logic [7:0] pick(input logic [47:0] s, input logic [2:0] idx);
    logic [23:0] smp;
    logic [23:0] sh;
    int          k;
    smp = (int'(idx) < SB) ? s[47:24] : s[23:0];
    k   = (int'(idx) < SB) ? int'(idx) : int'(idx) - SB;
    sh  = smp >> (16 - 8 * k);
    return sh[7:0];
  endfunction

  // Lowest selected channel above the current one (loop runs downward so
  // the lowest match is the last one written).
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int j = NCH - 1; j >= 1; j--) begin
      if (j > int'(ch) && mask_q[j]) begin
        nxt_found = 1'b1;
        nxt_ch    = CW'(j);
      end
    end
  end

  // Sample holding registers: only loaded on a ready edge into an empty slot.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NCH; k++) begin
      if (rise[k] && !avail[k]) begin
        hold[k] <= bus.iq_in[48*k +: 48];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_CLEAR;
      fifo_clear <= 1'b1;
      pend       <= 1'b0;
      data_q     <= '0;
      avail      <= '0;
      overrun    <= '0;
      rdy_q      <= '0;
      mask_q     <= '0;
      ch         <= '0;
      b          <= '0;
    end else begin
      rdy_q <= bus.rdy;

      for (int k = 0; k < NCH; k++) begin
        if (rise[k]) begin
          if (!avail[k]) avail[k]   <= 1'b1;
          else           overrun[k] <= 1'b1;
        end
      end

      // State actions below come after capture so that clears win.
      case (state)
        S_CLEAR: begin
          fifo_clear <= 1'b0;
          avail      <= '0;
          overrun    <= '0;
          pend       <= 1'b0;
          state      <= S_IDLE;
        end

        S_IDLE: begin
          if (eff_mask != mask_q) begin
            mask_q     <= eff_mask;
            fifo_clear <= 1'b1;
            state      <= S_CLEAR;
          end else if (bus.fifo_full) begin
            fifo_clear <= 1'b1;
            state      <= S_CLEAR;
          end else if (avail[0]) begin
            mask_q <= eff_mask;
            ch     <= '0;
            b      <= '0;
            data_q <= {1'b1, pick(hold[0], 3'd0)};
            pend   <= 1'b1;
            state  <= S_SEND;
          end
        end

        S_SEND: begin
          // Advance only once the presented byte has actually been accepted.
          if (!bus.fifo_full) begin
            if (b == LAST) begin
              avail[ch] <= 1'b0;
              b         <= '0;
              if (nxt_found) begin
                ch <= nxt_ch;
                if (avail[nxt_ch]) begin
                  data_q <= {1'b1, pick(hold[nxt_ch], 3'd0)};
                end else begin
                  pend  <= 1'b0;
                  state <= S_WAITCH;
                end
              end else begin
                pend  <= 1'b0;
                state <= S_GAP;
              end
            end else begin
              b      <= b + 3'd1;
              data_q <= {1'b0, pick(hold[ch], b + 3'd1)};
            end
          end
        end

        S_WAITCH: begin
          if (avail[ch]) begin
            data_q <= {1'b1, pick(hold[ch], 3'd0)};
            pend   <= 1'b1;
            state  <= S_SEND;
          end
        end

        S_GAP: begin
          state <= S_IDLE;
        end

        default: begin
          pend  <= 1'b0;
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
